// File: rtl/seq_alu.sv
// seq_alu: multi-cycle ALU with a start/done handshake.
//   Single-cycle ops complete one edge after accept. DIVMOD with a nonzero
//   divisor runs a restoring divider (one quotient bit per cycle, MSB first)
//   and completes WIDTH+1 edges after accept.
// Ports:
//   clk, rst            clock, async active-high reset
//   start, op, a, b     issue request (sampled only when ready=1)
//   ready               may accept start this cycle
//   done                one-cycle pulse, results valid
//   result_lo/hi        primary result / MUL high half or remainder
//   flag_z/c/v/dz       zero, carry/borrow, signed overflow, divide-by-zero
module seq_alu #(
  parameter int WIDTH = 16,
  parameter int OPW   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [OPW-1:0]   op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic             flag_z,
  output logic             flag_c,
  output logic             flag_v,
  output logic             flag_dz
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [OPW-1:0] OP_ADD = OPW'(4'h0), OP_SUB = OPW'(4'h1),
                             OP_INC = OPW'(4'h2), OP_DEC = OPW'(4'h3),
                             OP_MUL = OPW'(4'h4), OP_SHR = OPW'(4'h5),
                             OP_SHL = OPW'(4'h6), OP_AND = OPW'(4'h7),
                             OP_OR  = OPW'(4'h8), OP_XOR = OPW'(4'h9),
                             OP_NOT = OPW'(4'hA), OP_DIV = OPW'(4'hB);
  localparam logic [WIDTH-1:0] WIDTH_V = WIDTH'(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DIV} state_t;
  state_t state, state_nx;

  logic [OPW-1:0]   op_r;
  logic [WIDTH-1:0] a_r, b_r;
  logic [WIDTH-1:0] quo, rem;
  logic [CW-1:0]    cnt;
  logic             accept, div_last;

  // Final DIV cycle only transfers quo/rem to the outputs, so it can
  // overlap with accepting the next op just like an EXEC cycle.
  assign div_last = (state == S_DIV) && (cnt == CW'(WIDTH));
  assign accept   = start && ready;

  always_comb begin
    state_nx = state;
    ready    = 1'b0;
    case (state)
      S_IDLE:  ready = 1'b1;
      S_EXEC:  ready = 1'b1;
      S_DIV:   ready = div_last;
      default: ready = 1'b0;
    endcase
    if (accept)
      state_nx = (op == OP_DIV && b != '0) ? S_DIV : S_EXEC;
    else if (state == S_EXEC || div_last)
      state_nx = S_IDLE;
  end

  // Single-cycle datapath on the latched operands
  logic [WIDTH-1:0]   alu_lo, alu_hi;
  logic               alu_c, alu_v, alu_dz;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] prod;

  always_comb begin
    alu_lo = '0;
    alu_hi = '0;
    alu_c  = 1'b0;
    alu_v  = 1'b0;
    alu_dz = 1'b0;
    sum    = '0;
    prod   = '0;
    case (op_r)
      OP_ADD: begin
        sum    = {1'b0, a_r} + {1'b0, b_r};
        alu_lo = sum[WIDTH-1:0];
        alu_c  = sum[WIDTH];
        alu_v  = (a_r[WIDTH-1] == b_r[WIDTH-1]) && (alu_lo[WIDTH-1] != a_r[WIDTH-1]);
      end
      OP_SUB: begin
        sum    = {1'b0, a_r} - {1'b0, b_r};
        alu_lo = sum[WIDTH-1:0];
        alu_c  = sum[WIDTH];
        alu_v  = (a_r[WIDTH-1] != b_r[WIDTH-1]) && (alu_lo[WIDTH-1] != a_r[WIDTH-1]);
      end
      OP_INC: begin
        sum    = {1'b0, b_r} + 1'b1;
        alu_lo = sum[WIDTH-1:0];
        alu_c  = sum[WIDTH];
        alu_v  = !b_r[WIDTH-1] && alu_lo[WIDTH-1];
      end
      OP_DEC: begin
        sum    = {1'b0, b_r} - 1'b1;
        alu_lo = sum[WIDTH-1:0];
        alu_c  = sum[WIDTH];
        alu_v  = b_r[WIDTH-1] && !alu_lo[WIDTH-1];
      end
      OP_MUL: begin
        prod             = {{WIDTH{1'b0}}, a_r} * {{WIDTH{1'b0}}, b_r};
        {alu_hi, alu_lo} = prod;
      end
      OP_SHR: alu_lo = (b_r >= WIDTH_V) ? '0 : (a_r >> b_r);
      OP_SHL: alu_lo = (b_r >= WIDTH_V) ? '0 : (a_r << b_r);
      OP_AND: alu_lo = a_r & b_r;
      OP_OR:  alu_lo = a_r | b_r;
      OP_XOR: alu_lo = a_r ^ b_r;
      OP_NOT: alu_lo = ~b_r;
      OP_DIV: begin  // only reaches EXEC with b==0
        alu_lo = '1;
        alu_hi = a_r;
        alu_dz = 1'b1;
      end
      default: ;     // illegal opcodes: all zero
    endcase
  end

  // Restoring divider step: shift next dividend bit into the partial
  // remainder, subtract divisor if it fits. rem < b keeps diff in WIDTH bits.
  logic [WIDTH:0]   shifted, diff;
  logic             fits;
  assign shifted = {rem, quo[WIDTH-1]};
  assign diff    = shifted - {1'b0, b_r};
  assign fits    = !diff[WIDTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      op_r      <= '0;
      a_r       <= '0;
      b_r       <= '0;
      quo       <= '0;
      rem       <= '0;
      cnt       <= '0;
      done      <= 1'b0;
      result_lo <= '0;
      result_hi <= '0;
      flag_z    <= 1'b0;
      flag_c    <= 1'b0;
      flag_v    <= 1'b0;
      flag_dz   <= 1'b0;
    end else begin
      state <= state_nx;
      done  <= 1'b0;
      if (state == S_EXEC) begin
        result_lo <= alu_lo;
        result_hi <= alu_hi;
        flag_z    <= (alu_lo == '0);
        flag_c    <= alu_c;
        flag_v    <= alu_v;
        flag_dz   <= alu_dz;
        done      <= 1'b1;
      end else if (div_last) begin
        result_lo <= quo;
        result_hi <= rem;
        flag_z    <= (quo == '0);
        flag_c    <= 1'b0;
        flag_v    <= 1'b0;
        flag_dz   <= 1'b0;
        done      <= 1'b1;
      end else if (state == S_DIV) begin
        rem <= fits ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
        quo <= {quo[WIDTH-2:0], fits};
        cnt <= cnt + CW'(1);
      end
      if (accept) begin
        op_r <= op;
        a_r  <= a;
        b_r  <= b;
        quo  <= a;
        rem  <= '0;
        cnt  <= '0;
      end
    end
  end
endmodule

// File: tb/tb_seq_alu.sv
module tb_seq_alu;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // 16-bit instance
  logic        start, ready, done, z, c, v, dz;
  logic [3:0]  op;
  logic [15:0] a, b, lo, hi;
  // 8-bit regression instance
  logic        start8, ready8, done8, z8, c8, v8, dz8;
  logic [3:0]  op8;
  logic [7:0]  a8, b8, lo8, hi8;

  seq_alu #(.WIDTH(16), .OPW(4)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .ready(ready), .done(done), .result_lo(lo), .result_hi(hi),
    .flag_z(z), .flag_c(c), .flag_v(v), .flag_dz(dz));

  seq_alu #(.WIDTH(8), .OPW(4)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .op(op8), .a(a8), .b(b8),
    .ready(ready8), .done(done8), .result_lo(lo8), .result_hi(hi8),
    .flag_z(z8), .flag_c(c8), .flag_v(v8), .flag_dz(dz8));

  int total = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  typedef struct packed {
    logic [31:0] lo;
    logic [31:0] hi;
    logic [3:0]  flags;  // {z,c,v,dz}
  } res_t;

  // Signed value of a w-bit pattern
  function automatic longint sx(input int w, input longint unsigned x);
    longint unsigned half = 64'd1 << (w - 1);
    return (x >= half) ? longint'(x) - longint'(half * 2) : longint'(x);
  endfunction

  function automatic bit ovf(input int w, input longint s);
    longint lim = longint'(64'd1 << (w - 1));
    return (s < -lim) || (s > lim - 1);
  endfunction

  // Reference: results straight from the arithmetic definitions
  function automatic res_t model(input int w, input logic [3:0] o,
                                 input longint unsigned x, input longint unsigned y);
    longint unsigned m = (64'd1 << w) - 1;
    longint unsigned rl = 0, rh = 0, p;
    bit fc = 0, fv = 0, fdz = 0;
    res_t r;
    case (o)
      4'h0: begin rl = (x + y) & m; fc = (x + y) > m; fv = ovf(w, sx(w, x) + sx(w, y)); end
      4'h1: begin rl = (x - y) & m; fc = x < y;       fv = ovf(w, sx(w, x) - sx(w, y)); end
      4'h2: begin rl = (y + 1) & m; fc = (y == m);    fv = ovf(w, sx(w, y) + 1); end
      4'h3: begin rl = (y - 1) & m; fc = (y == 0);    fv = ovf(w, sx(w, y) - 1); end
      4'h4: begin p = x * y; rl = p & m; rh = p >> w; end
      4'h5: rl = (y >= longint'(w)) ? 0 : (x >> y);
      4'h6: rl = (y >= longint'(w)) ? 0 : ((x << y) & m);
      4'h7: rl = x & y;
      4'h8: rl = x | y;
      4'h9: rl = x ^ y;
      4'hA: rl = ~y & m;
      4'hB: begin
        if (y == 0) begin rl = m; rh = x; fdz = 1; end
        else begin rl = x / y; rh = x % y; end
      end
      default: ;
    endcase
    r.lo    = 32'(rl);
    r.hi    = 32'(rh);
    r.flags = {rl == 0, fc, fv, fdz};
    return r;
  endfunction

  task automatic run16(input logic [3:0] o, input logic [15:0] x, input logic [15:0] y,
                       input bit poke, input string tag);
    res_t e = model(16, o, x, y);
    int lat = (o == 4'hB && y != 0) ? 17 : 1;
    int n = 0;
    @(negedge clk);
    chk({tag, "/ready"}, ready, 1);
    start = 1; op = o; a = x; b = y;
    @(negedge clk);
    // scramble inputs: operands must have been captured at accept
    start = 0; op = 4'($urandom); a = 16'($urandom); b = 16'($urandom);
    while (!done && n < 40) begin
      if (poke && n == 3) start = 1;
      if (poke && n == 4) start = 0;
      if (lat > 1 && n == 1) chk({tag, "/busy"}, ready, 0);
      @(negedge clk);
      n++;
    end
    chk({tag, "/lat"}, n, lat);
    chk({tag, "/lo"}, lo, e.lo);
    chk({tag, "/hi"}, hi, e.hi);
    chk({tag, "/flags"}, {z, c, v, dz}, e.flags);
    @(negedge clk);
    chk({tag, "/pulse"}, done, 0);
  endtask

  task automatic run8(input logic [3:0] o, input logic [7:0] x, input logic [7:0] y);
    res_t e = model(8, o, x, y);
    int lat = (o == 4'hB && y != 0) ? 9 : 1;
    int n = 0;
    @(negedge clk);
    start8 = 1; op8 = o; a8 = x; b8 = y;
    @(negedge clk);
    start8 = 0; a8 = 8'($urandom); b8 = 8'($urandom);
    while (!done8 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("w8/lat", n, lat);
    chk("w8/res", {lo8, hi8, z8, c8, v8, dz8}, {e.lo[7:0], e.hi[7:0], e.flags});
  endtask

  initial begin
    res_t q[$];
    res_t ex;
    bit seen;
    logic [3:0] o;
    logic [15:0] y;

    rst = 1; start = 0; op = 0; a = 0; b = 0;
    start8 = 0; op8 = 0; a8 = 0; b8 = 0;
    #12;
    chk("rst/state", {ready, done, lo, hi, z, c, v, dz}, {1'b1, 1'b0, 32'h0, 4'h0});
    chk("rst/state8", {ready8, done8, lo8, hi8, z8, c8, v8, dz8}, {1'b1, 1'b0, 16'h0, 4'h0});
    @(negedge clk); rst = 0;

    // directed corner cases
    run16(4'h0, 16'hFFFF, 16'h0001, 0, "add_wrap");
    run16(4'h1, 16'h8000, 16'h0001, 0, "sub_ovf");
    run16(4'h4, 16'hFFFF, 16'hFFFF, 0, "mul_max");
    run16(4'hB, 16'h0064, 16'h0007, 1, "div_100_7");
    run16(4'hB, 16'h1234, 16'h0000, 0, "div_zero");
    run16(4'h6, 16'h0001, 16'h0010, 0, "shl_w");
    run16(4'h5, 16'h8000, 16'h000F, 0, "shr_15");
    run16(4'h2, 16'h0000, 16'h7FFF, 0, "inc_ovf");
    run16(4'h3, 16'h0000, 16'h0000, 0, "dec_borrow");
    run16(4'hD, 16'h1234, 16'h5678, 0, "illegal");
    run16(4'hB, 16'hFFFF, 16'h0001, 0, "div_by1");

    // reset during a division: abort, no done
    @(negedge clk);
    start = 1; op = 4'hB; a = 16'hBEEF; b = 16'h0007;
    @(negedge clk); start = 0;
    repeat (4) @(negedge clk);
    rst = 1;
    #1;
    chk("rstdiv/state", {ready, done, lo, hi, z, c, v, dz}, {1'b1, 1'b0, 32'h0, 4'h0});
    @(negedge clk); rst = 0;
    seen = 0;
    repeat (25) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    chk("rstdiv/nodone", seen, 0);

    // back-to-back AND/OR/XOR stream with start held
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      if (k >= 2) begin
        ex = q.pop_front();
        chk("b2b/done", done, 1);
        chk("b2b/lo", lo, ex.lo);
      end
      if (k < 12) begin
        chk("b2b/ready", ready, 1);
        start = 1;
        op = 4'(7 + k % 3); a = 16'($urandom); b = 16'($urandom);
        q.push_back(model(16, op, a, b));
      end else begin
        start = 0;
      end
    end
    @(negedge clk);
    chk("b2b/end", done, 0);

    // randomized ops against the model
    for (int k = 0; k < 40; k++) begin
      o = 4'($urandom_range(0, 15));
      y = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 20)) : 16'($urandom);
      run16(o, 16'($urandom), y, 1'($urandom), "rand");
    end

    // narrow-width regression
    run8(4'hB, 8'hC8, 8'h07);
    run8(4'h4, 8'hFF, 8'hFF);
    run8(4'h0, 8'h7F, 8'h01);
    for (int k = 0; k < 20; k++)
      run8(4'($urandom_range(0, 15)), 8'($urandom),
           ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 10)) : 8'($urandom));

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end
endmodule
